// File: rtl/demux_router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_router_pkg : shared constants and helpers for demux_router   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package demux_router_pkg;

  localparam int SEL_W               = 3;
  localparam int MAX_CH              = 1 << SEL_W;
  localparam logic [SEL_W-1:0] BCAST_SEL = 3'b111;
  localparam int DROP_CNT_W          = 8;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_chan_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_chan_fifo : single-clock FIFO for one router output channel  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module demux_chan_fifo
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared too so that out_data reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_router : routes one input stream to CHANNELS buffered outputs|
// | Option macro: DEMUX_ROUTER_BCAST_EN (in_sel=3'b111 broadcasts)     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module demux_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [DROP_CNT_W-1:0]     drop_cnt
);

  localparam logic [SEL_W:0] CH_LIMIT = (SEL_W+1)'(CHANNELS);

  logic [CHANNELS-1:0] full;
  logic [CHANNELS-1:0] empty;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] route;
  logic [CHANNELS-1:0] push;
  logic [MAX_CH-1:0]   full_pad;
  logic                sel_ok;
  logic                drop;

  assign sel_ok = ({1'b0, in_sel} < CH_LIMIT);

  // Unused select codes read as full; they are never reached when sel_ok.
  always_comb begin
    full_pad               = '1;
    full_pad[CHANNELS-1:0] = full;
  end

`ifdef DEMUX_ROUTER_BCAST_EN
  logic is_bcast;
  assign is_bcast = (in_sel == BCAST_SEL);
  assign in_ready = is_bcast ? ~|full : (sel_ok ? !full_pad[in_sel] : 1'b1);
  assign route    = is_bcast ? '1 : sel_hit;
  assign drop     = in_valid && !is_bcast && !sel_ok;
`else
  assign in_ready = sel_ok ? !full_pad[in_sel] : 1'b1;
  assign route    = sel_hit;
  assign drop     = in_valid && !sel_ok;
`endif

  assign push      = route & {CHANNELS{in_valid && in_ready}};
  assign out_valid = ~empty;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam logic [SEL_W-1:0] IDX = SEL_W'(i);

    assign sel_hit[i] = (in_sel == IDX);

    demux_chan_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[i]),
      .push_data (in_data),
      .pop       (out_ready[i] && !empty[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .head      (out_data[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_demux_router : scoreboard bench for demux_router                |
// | Honours DEMUX_ROUTER_BCAST_EN for the broadcast scenario.          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_demux_router;
  import demux_router_pkg::*;

  localparam int W     = 8;
  localparam int CH    = 3;
  localparam int DEPTH = 2;
`ifdef DEMUX_ROUTER_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [2:0]    in_sel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0] out_valid;
  logic [CH-1:0] out_ready = '0;
  logic [7:0]    drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_router #(.WIDTH(W), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-channel queues of words and a saturating drop tally.
  logic [W-1:0] exp_q [CH][$];
  int           mcnt [CH];
  int           mdrop;

  function automatic bit model_ready();
    bit r;
    r = 1'b1;
    if (BCAST && in_sel == 3'd7) begin
      for (int i = 0; i < CH; i++) if (mcnt[i] >= DEPTH) r = 1'b0;
    end else if (int'(in_sel) < CH) begin
      r = (mcnt[in_sel] < DEPTH);
    end
    return r;
  endfunction

  function automatic logic [CH-1:0] model_valid();
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = (mcnt[i] > 0);
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        exp_q[i].delete();
        mcnt[i] = 0;
      end
      mdrop = 0;
    end else begin
      acc = in_valid && model_ready();
      for (int i = 0; i < CH; i++) if (out_ready[i] && mcnt[i] > 0) mcnt[i]--;
      if (acc) begin
        if (BCAST && in_sel == 3'd7) begin
          for (int i = 0; i < CH; i++) begin
            exp_q[i].push_back(in_data);
            mcnt[i]++;
          end
        end else if (int'(in_sel) < CH) begin
          exp_q[in_sel].push_back(in_data);
          mcnt[in_sel]++;
        end else if (mdrop < 255) begin
          mdrop++;
        end
      end
    end
  end

  // Monitor: compares handshake state every cycle and pops the scoreboard on each output transfer.
  always @(negedge clk) begin
    check("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    check("out_valid", {29'd0, out_valid}, {29'd0, model_valid()});
    check("drop_cnt", {24'd0, drop_cnt}, mdrop);
    if (rst_n) begin
      for (int i = 0; i < CH; i++) begin
        if (out_ready[i] && mcnt[i] > 0) begin
          if (exp_q[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL ch%0d_data: got %0h expected nothing (scoreboard empty)", i, out_data[i*W +: W]);
          end else begin
            check($sformatf("ch%0d_data", i), {24'd0, out_data[i*W +: W]}, {24'd0, exp_q[i].pop_front()});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] sel, input logic [W-1:0] d);
    int n;
    in_sel   = sel;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance within 50 cycles (sel %0d)", sel);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_data", {8'd0, out_data}, 32'd0);
    check("rst_in_ready_during", {31'd0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {29'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    step();

    // Routing with one-cycle latency
    out_ready = '1;
    send(3'd1, 8'hA5);
    @(negedge clk);
    check("route_valid", {29'd0, out_valid}, 32'b010);
    check("route_data", {24'd0, out_data[15:8]}, 32'hA5);
    @(negedge clk);
    check("route_drained", {29'd0, out_valid}, 32'd0);
    step();

    // Full-channel backpressure
    out_ready = 3'b110;
    send(3'd0, 8'h11);
    send(3'd0, 8'h22);
    in_sel = 3'd0; in_data = 8'h33; in_valid = 1'b1;
    @(negedge clk);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    step();
    in_sel = 3'd2; in_data = 8'h44;
    @(negedge clk);
    check("bp_other_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_sel = 3'd0; in_data = 8'h33;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", {31'd0, in_ready}, 32'd0);
    end
    step();
    out_ready[0] = 1'b1;
    send(3'd0, 8'h33);
    out_ready = '1;
    repeat (4) step();
    @(negedge clk);
    check("bp_drained", {29'd0, out_valid}, 32'd0);
    step();

    // Invalid select drops and saturates
    in_sel = 3'd4; in_data = 8'hEE; in_valid = 1'b1;
    repeat (300) step();
    in_valid = 1'b0;
    @(negedge clk);
    check("drop_sat", {24'd0, drop_cnt}, 32'd255);
    check("drop_no_valid", {29'd0, out_valid}, 32'd0);
    step();

    // Simultaneous push and pop on channel 2
    out_ready = 3'b011;
    send(3'd2, 8'h3C);
    in_sel = 3'd2; in_data = 8'h5A; in_valid = 1'b1; out_ready[2] = 1'b1;
    @(negedge clk);
    check("pp_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0; out_ready[2] = 1'b0;
    @(negedge clk);
    check("pp_valid", {31'd0, out_valid[2]}, 32'd1);
    check("pp_head", {24'd0, out_data[23:16]}, 32'h5A);
    step();
    out_ready[2] = 1'b1;
    step();
    @(negedge clk);
    check("pp_single", {31'd0, out_valid[2]}, 32'd0);
    step();

`ifdef DEMUX_ROUTER_BCAST_EN
    // Broadcast blocked by a full channel
    out_ready = '0;
    send(3'd1, 8'hB1);
    send(3'd1, 8'hB2);
    in_sel = 3'd7; in_data = 8'h7E; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bc_blocked", {31'd0, in_ready}, 32'd0);
    end
    step();
    out_ready[1] = 1'b1;
    step();
    out_ready[1] = 1'b0;
    send(3'd7, 8'h7E);
    out_ready[1] = 1'b1;
    step();
    out_ready[1] = 1'b0;
    @(negedge clk);
    check("bc_valid", {29'd0, out_valid}, 32'b111);
    for (int i = 0; i < CH; i++)
      check($sformatf("bc_data%0d", i), {24'd0, out_data[i*W +: W]}, 32'h7E);
    step();
    out_ready = '1;
    repeat (4) step();
`endif

    // Randomised traffic against the model
    repeat (600) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = W'($urandom);
      out_ready = CH'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = '1;
    repeat (4) step();

    // Reset asserted mid-transfer
    out_ready = '0;
    in_sel = 3'd0; in_data = 8'h99; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_valid", {29'd0, out_valid}, 32'd0);
    check("rstmid_drop", {24'd0, drop_cnt}, 32'd0);
    check("rstmid_ready", {31'd0, in_ready}, 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
